// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_word_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID output register: PC generation, single-outstanding
// req/gnt/rvalid fetch, stall buffering, delay-slot branches and flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_inst_o,
  output logic            if_valid_o
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifl_pc_q, ifl_pc_d;
  logic [XLEN-1:0] br_tgt_q, br_tgt_d;
  logic            br_pend_q, br_pend_d;
  logic            drop_q, drop_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  fetch_word_t     hold_q, hold_d;
  fetch_word_t     out_q, out_d;

  logic            gnt_ok;
  logic            take_br;
  logic            new_word;
  fetch_word_t     new_data;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      ifl_pc_q  <= '0;
      br_tgt_q  <= '0;
      br_pend_q <= 1'b0;
      drop_q    <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ifl_pc_q  <= ifl_pc_d;
      br_tgt_q  <= br_tgt_d;
      br_pend_q <= br_pend_d;
      drop_q    <= drop_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
    end
  end

  // Next-state, PC and IF/ID register update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifl_pc_d  = ifl_pc_q;
    br_tgt_d  = br_tgt_q;
    br_pend_d = br_pend_q;
    drop_d    = drop_q;
    hold_d    = hold_q;
    out_d     = out_q;
    valid_d   = valid_q;
    req_d     = 1'b0;
    new_word  = 1'b0;
    new_data  = hold_q;
    gnt_ok    = req_q & imem_gnt_i;
    take_br   = branch_flag_i & ~stall_i;

    case (state_q)
      S_REQ: begin
        if (gnt_ok) begin
          state_d   = S_WAIT;
          ifl_pc_d  = pc_q;
          br_pend_d = 1'b0;
          pc_d      = br_pend_q ? br_tgt_q : pc_q + XLEN'(PC_STEP);
          if (take_br) pc_d = branch_target_i;
        end else if (take_br) begin
          // Delay slot still to be requested at pc_q; redirect after it is granted
          br_pend_d = 1'b1;
          br_tgt_d  = branch_target_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!stall_i) begin
            new_word = 1'b1;
            new_data = '{pc: ifl_pc_q, inst: imem_rdata_i};
          end else begin
            hold_d  = '{pc: ifl_pc_q, inst: imem_rdata_i};
            state_d = S_HOLD;
          end
        end
        if (take_br && !drop_q) pc_d = branch_target_i;
      end
      S_HOLD: begin
        if (!stall_i) begin
          new_word = 1'b1;
          state_d  = S_REQ;
        end
        if (take_br) pc_d = branch_target_i;
      end
      default: state_d = S_REQ;
    endcase

    if (!stall_i) begin
      valid_d = new_word;
      if (new_word) out_d = new_data;
      else          out_d.inst = ZERO_WORD;
    end

    // Flush overrides everything; a request already accepted by memory must be drained
    if (flush_i) begin
      pc_d       = flush_pc_i;
      br_pend_d  = 1'b0;
      valid_d    = 1'b0;
      out_d.inst = ZERO_WORD;
      drop_d     = 1'b0;
      state_d    = S_REQ;
      if ((state_q == S_WAIT && !imem_rvalid_i) || (state_q == S_REQ && gnt_ok)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end
    end

    req_d = (state_d == S_REQ);
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign if_pc_o     = out_q.pc;
  assign if_inst_o   = out_q.inst;
  assign if_valid_o  = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, stall buffering, branches, flush, wrap, async reset.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = 32'h0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 0;
  logic        pend   = 1'b0;
  int          cnt    = 0;
  logic [31:0] paddr  = 32'h0;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at address a is a ^ 32'hC0DE_0000, returned lat cycles after the grant cycle
  always @(posedge clk) begin : mem_model
    logic        g;
    logic [31:0] a;
    g = imem_req_o & imem_gnt_i;
    a = imem_addr_o;
    #1;
    imem_rvalid_i = 1'b0;
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (g) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = a;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr ^ 32'hC0DE_0000;
          pend          = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    branch_flag_i = 1'b0; branch_target_i = 32'h0; imem_gnt_i = 1'b1; lat = 0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    branch_flag_i = 1'b0; branch_target_i = 32'h0; imem_gnt_i = 1'b1; lat = 0;
    step(2);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", if_inst_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", if_valid_o); end
    rst = 1'b1;
    step(1);
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL release_req got %h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL release_addr got %h exp 0", imem_addr_o); end
  endtask

  task automatic test_sequential();
    apply_reset();
    step(2);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL seq_wait_req got %h exp 0", imem_req_o); end
    step(1);
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL seq_w0_valid got %h exp 1", if_valid_o); end
    checks++; if (if_inst_o !== 32'hC0DE_0000) begin errors++; $display("FAIL seq_w0_inst got %h exp c0de0000", if_inst_o); end
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL seq_addr4 got %h exp 4", imem_addr_o); end
    step(1);
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL seq_bubble_valid got %h exp 0", if_valid_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL seq_bubble_inst got %h exp 0", if_inst_o); end
    step(1);
    checks++; if (if_inst_o !== 32'hC0DE_0004) begin errors++; $display("FAIL seq_w4_inst got %h exp c0de0004", if_inst_o); end
    checks++; if (if_pc_o !== 32'h4) begin errors++; $display("FAIL seq_w4_pc got %h exp 4", if_pc_o); end
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL seq_addr8 got %h exp 8", imem_addr_o); end
    step(2);
    checks++; if (if_pc_o !== 32'h8) begin errors++; $display("FAIL seq_w8_pc got %h exp 8", if_pc_o); end
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL seq_addrc got %h exp c", imem_addr_o); end
  endtask

  task automatic test_stall();
    apply_reset();
    step(3);
    stall_i = 1'b1;
    step(2);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold_req got %h exp 0", imem_req_o); end
    checks++; if (if_inst_o !== 32'hC0DE_0000) begin errors++; $display("FAIL stall_hold_inst got %h exp c0de0000", if_inst_o); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold_valid got %h exp 1", if_valid_o); end
    step(1);
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL stall_hold_pc got %h exp 0", if_pc_o); end
    stall_i = 1'b0;
    step(1);
    checks++; if (if_inst_o !== 32'hC0DE_0004) begin errors++; $display("FAIL stall_rel_inst got %h exp c0de0004", if_inst_o); end
    checks++; if (if_pc_o !== 32'h4) begin errors++; $display("FAIL stall_rel_pc got %h exp 4", if_pc_o); end
    checks++; if (imem_addr_o !== 32'h8 || imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_rel_req got %h/%h exp 1/8", imem_req_o, imem_addr_o); end
    step(2);
    checks++; if (if_inst_o !== 32'hC0DE_0008) begin errors++; $display("FAIL stall_next_inst got %h exp c0de0008", if_inst_o); end
  endtask

  task automatic test_branch_wait();
    apply_reset();
    step(6);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step(1);
    branch_flag_i = 1'b0;
    checks++; if (if_inst_o !== 32'hC0DE_0008) begin errors++; $display("FAIL brw_slot_inst got %h exp c0de0008", if_inst_o); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL brw_slot_valid got %h exp 1", if_valid_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL brw_target_addr got %h exp 100", imem_addr_o); end
    step(2);
    checks++; if (if_pc_o !== 32'h100) begin errors++; $display("FAIL brw_target_pc got %h exp 100", if_pc_o); end
    checks++; if (if_inst_o !== 32'hC0DE_0100) begin errors++; $display("FAIL brw_target_inst got %h exp c0de0100", if_inst_o); end
  endtask

  task automatic test_branch_req();
    apply_reset();
    step(4);
    imem_gnt_i = 1'b0;
    step(1);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL brr_c5_addr got %h exp 8", imem_addr_o); end
    step(1);
    branch_flag_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("FAIL brr_slot_addr got %h exp 8", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL brr_bubble got %h exp 0", if_valid_o); end
    step(1);
    checks++; if (imem_addr_o !== 32'h8 || imem_req_o !== 1'b1) begin errors++; $display("FAIL brr_slot_wait got %h/%h exp 1/8", imem_req_o, imem_addr_o); end
    step(1);
    imem_gnt_i = 1'b1;
    step(2);
    checks++; if (if_pc_o !== 32'h8) begin errors++; $display("FAIL brr_slot_pc got %h exp 8", if_pc_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL brr_target_addr got %h exp 100", imem_addr_o); end
    step(2);
    checks++; if (if_inst_o !== 32'hC0DE_0100) begin errors++; $display("FAIL brr_target_inst got %h exp c0de0100", if_inst_o); end
    checks++; if (imem_addr_o !== 32'h104) begin errors++; $display("FAIL brr_seq_addr got %h exp 104", imem_addr_o); end
  endtask

  task automatic test_flush();
    apply_reset();
    step(3);
    stall_i = 1'b1; lat = 2;
    step(1);
    checks++; if (if_inst_o !== 32'hC0DE_0000 || if_valid_o !== 1'b1) begin errors++; $display("FAIL fl_pre got %h/%h exp c0de0000/1", if_inst_o, if_valid_o); end
    flush_i = 1'b1; flush_pc_i = 32'h180; stall_i = 1'b0;
    step(1);
    flush_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL fl_bubble_valid got %h exp 0", if_valid_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL fl_bubble_inst got %h exp 0", if_inst_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL fl_drain_req got %h exp 0", imem_req_o); end
    step(2);
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL fl_late_discard got %h exp 0", if_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h180) begin errors++; $display("FAIL fl_restart got %h/%h exp 1/180", imem_req_o, imem_addr_o); end
    step(4);
    checks++; if (if_inst_o !== 32'hC0DE_0180 || if_pc_o !== 32'h180) begin errors++; $display("FAIL fl_new_word got %h/%h exp c0de0180/180", if_inst_o, if_pc_o); end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(1);
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    step(1);
    flush_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_drain_req got %h exp 0", imem_req_o); end
    step(1);
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC || if_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_gnt_drop got %h/%h exp fffffffc/0", imem_addr_o, if_valid_o); end
    step(2);
    checks++; if (if_inst_o !== 32'h3F21_FFFC) begin errors++; $display("FAIL wrap_inst got %h exp 3f21fffc", if_inst_o); end
    checks++; if (if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", if_pc_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(5);
    stall_i = 1'b1;
    step(1);
    checks++; if (if_inst_o !== 32'hC0DE_0004) begin errors++; $display("FAIL ar_pre_inst got %h exp c0de0004", if_inst_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %h exp 0", if_valid_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL ar_inst got %h exp 0", if_inst_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL ar_pc got %h exp 0", if_pc_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL ar_addr got %h exp 0", imem_addr_o); end
    stall_i = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL ar_restart got %h/%h exp 1/0", imem_req_o, imem_addr_o); end
    step(2);
    checks++; if (if_inst_o !== 32'hC0DE_0000 || if_valid_o !== 1'b1) begin errors++; $display("FAIL ar_first_word got %h/%h exp c0de0000/1", if_inst_o, if_valid_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_req();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
